sad_min_select: RTL and testbench

SAD_MIN_SELECT -- requirements
Module: sad_min_select

---
 rtl/sad_pkg.sv | 35 +++
 rtl/sad_min_lane.sv | 34 +++
 rtl/sad_min_select.sv | 100 ++++++++++
 tb/tb_sad_min_select.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared constants for the SAD minimum-select block: lane layout per
// partition type and the controller state encoding.
package sad_pkg;

  localparam int NUM_LANES = 41;

  // First lane of each partition group inside the packed SAD/MV vectors
  localparam int LANE_4X4   = 0;
  localparam int LANE_8X4   = 16;
  localparam int LANE_4X8   = 24;
  localparam int LANE_8X8   = 32;
  localparam int LANE_16X8  = 36;
  localparam int LANE_8X16  = 38;
  localparam int LANE_16X16 = 40;

  localparam int NUM_4X4   = LANE_8X4   - LANE_4X4;
  localparam int NUM_8X4   = LANE_4X8   - LANE_8X4;
  localparam int NUM_4X8   = LANE_8X8   - LANE_4X8;
  localparam int NUM_8X8   = LANE_16X8  - LANE_8X8;
  localparam int NUM_16X8  = LANE_8X16  - LANE_16X8;
  localparam int NUM_8X16  = LANE_16X16 - LANE_8X16;
  localparam int NUM_16X16 = NUM_LANES  - LANE_16X16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Candidates per search: a square window of +/-sr in both axes
  function automatic int num_beats(input int sr);
    return (2 * sr + 1) * (2 * sr + 1);
  endfunction

endpackage

// File: rtl/sad_min_lane.sv
// One lane of the minimum tracker: keeps the smallest SAD seen so far and
// the motion vector of the candidate that produced it.
module sad_min_lane
  import sad_pkg::*;
#(
  parameter int SAD_W = 16,
  parameter int MV_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                beat,
  input  logic                first,
  input  logic [SAD_W-1:0]    sad,
  input  logic [2*MV_W-1:0]   mv,
  output logic [SAD_W-1:0]    best_sad,
  output logic [2*MV_W-1:0]   best_mv
);

  logic take;

  // Strict less-than so that on ties the earlier raster candidate is kept
  assign take = beat && (first || (sad < best_sad));

  always_ff @(posedge clk) begin
    if (rst) begin
      best_sad <= '1;
      best_mv  <= '0;
    end else if (take) begin
      best_sad <= sad;
      best_mv  <= mv;
    end
  end

endmodule

// File: rtl/sad_min_select.sv
// Motion-search minimum selector: walks the candidate window in raster order
// and keeps, per partition lane, the lowest SAD and its motion vector.
module sad_min_select
  import sad_pkg::*;
#(
  parameter int SR    = 8,
  parameter int SAD_W = 16,
  parameter int MV_W  = $clog2(SR + 1) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  input  logic                          sad_valid,
  input  logic [NUM_LANES*SAD_W-1:0]    sad_in,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [NUM_LANES*SAD_W-1:0]    best_sad,
  output logic [NUM_LANES*2*MV_W-1:0]   best_mv
);

  localparam int N_BEATS = num_beats(SR);
  localparam int CNT_W   = $clog2(N_BEATS + 1);

  localparam logic [MV_W-1:0]  MV_MIN   = MV_W'(-SR);
  localparam logic [MV_W-1:0]  MV_MAX   = MV_W'(SR);
  localparam logic [MV_W-1:0]  MV_ONE   = MV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BEATS - 1);

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  beat_cnt;
  logic [MV_W-1:0]   mv_x;
  logic [MV_W-1:0]   mv_y;
  logic              beat;
  logic              first_beat;
  logic              last_beat;
  logic [2*MV_W-1:0] mv_cur;

  assign beat       = (state == SEARCH) && sad_valid;
  assign first_beat = (beat_cnt == '0);
  assign last_beat  = (beat_cnt == CNT_LAST);
  assign mv_cur     = {mv_y, mv_x};

  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)              next_state = SEARCH;
      SEARCH:  if (beat && last_beat)  next_state = DONE;
      DONE:    if (res_ready)          next_state = IDLE;
      default:                         next_state = IDLE;
    endcase
  end

  // Only a start seen in IDLE re-arms the window; mid-search starts are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      mv_x     <= '0;
      mv_y     <= '0;
    end else begin
      state <= next_state;
      if ((state == IDLE) && start) begin
        beat_cnt <= '0;
        mv_x     <= MV_MIN;
        mv_y     <= MV_MIN;
      end else if (beat) begin
        beat_cnt <= beat_cnt + CNT_ONE;
        if (mv_x == MV_MAX) begin
          mv_x <= MV_MIN;
          mv_y <= mv_y + MV_ONE;
        end else begin
          mv_x <= mv_x + MV_ONE;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sad_min_lane #(
      .SAD_W (SAD_W),
      .MV_W  (MV_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .beat     (beat),
      .first    (first_beat),
      .sad      (sad_in[i*SAD_W +: SAD_W]),
      .mv       (mv_cur),
      .best_sad (best_sad[i*SAD_W +: SAD_W]),
      .best_mv  (best_mv[i*2*MV_W +: 2*MV_W])
    );
  end

endmodule

// File: tb/tb_sad_min_select.sv
// Randomised directed bench for sad_min_select at SR=1; expected results come
// from a per-lane argmin over the candidate table, scanned in raster order.
module tb_sad_min_select;

  localparam int SR      = 1;
  localparam int SAD_W   = 16;
  localparam int MV_W    = 2;
  localparam int LANES   = 41;
  localparam int SPAN    = 2 * SR + 1;
  localparam int N_BEATS = SPAN * SPAN;
  localparam int CW      = LANES * SAD_W;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic                      busy;
  logic                      sad_valid;
  logic [LANES*SAD_W-1:0]    sad_in;
  logic                      res_valid;
  logic                      res_ready;
  logic [LANES*SAD_W-1:0]    best_sad;
  logic [LANES*2*MV_W-1:0]   best_mv;

  int unsigned               tbl [N_BEATS][LANES];
  logic [LANES*SAD_W-1:0]    exp_sad;
  logic [LANES*2*MV_W-1:0]   exp_mv;
  logic [LANES*2*MV_W-1:0]   all_first_mv;
  int                        assertions = 0;
  int                        failures   = 0;

  sad_min_select #(
    .SR    (SR),
    .SAD_W (SAD_W),
    .MV_W  (MV_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .sad_valid (sad_valid),
    .sad_in    (sad_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .best_sad  (best_sad),
    .best_mv   (best_mv)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fillRandom(input int unsigned lo, input int unsigned hi);
    for (int k = 0; k < N_BEATS; k++)
      for (int l = 0; l < LANES; l++)
        tbl[k][l] = $urandom_range(hi, lo);
  endtask

  // Reference: lowest SAD per lane, first occurrence wins, MV from raster index
  task automatic buildModel();
    for (int l = 0; l < LANES; l++) begin
      int unsigned best;
      int idx;
      int x;
      int y;
      best = tbl[0][l];
      idx  = 0;
      for (int k = 1; k < N_BEATS; k++) begin
        if (tbl[k][l] < best) begin
          best = tbl[k][l];
          idx  = k;
        end
      end
      x = (idx % SPAN) - SR;
      y = (idx / SPAN) - SR;
      exp_sad[l*SAD_W +: SAD_W]   = SAD_W'(best);
      exp_mv[l*2*MV_W +: 2*MV_W]  = {MV_W'(y), MV_W'(x)};
    end
  endtask

  task automatic driveRow(input int k);
    for (int l = 0; l < LANES; l++)
      sad_in[l*SAD_W +: SAD_W] = SAD_W'(tbl[k][l]);
  endtask

  task automatic driveJunk();
    for (int l = 0; l < LANES; l++)
      sad_in[l*SAD_W +: SAD_W] = SAD_W'($urandom);
  endtask

  // Called on a falling edge; returns on the falling edge after the last beat
  task automatic applyStimulus(input int nbeats, input bit gaps, input bit poke_start);
    int k;
    int step;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k     = 0;
    step  = 0;
    while (k < nbeats) begin
      if (gaps && (step % 2 == 1)) begin
        sad_valid = 1'b0;
        driveJunk();
      end else begin
        sad_valid = 1'b1;
        driveRow(k);
        k++;
      end
      start = poke_start && (step == 2);
      checkOutput("res_valid_in_search", CW'(res_valid), CW'(1'b0));
      @(negedge clk);
      checkOutput("busy_in_search", CW'(busy), CW'(1'b1));
      step++;
    end
    sad_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic checkResults(input string tag);
    checkOutput({tag, "_res_valid"}, CW'(res_valid), CW'(1'b1));
    checkOutput({tag, "_best_sad"}, best_sad, exp_sad);
    checkOutput({tag, "_best_mv"}, CW'(best_mv), CW'(exp_mv));
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy"}, CW'(busy), CW'(1'b0));
    checkOutput({tag, "_res_valid"}, CW'(res_valid), CW'(1'b0));
    checkOutput({tag, "_best_sad"}, best_sad, {CW{1'b1}});
    checkOutput({tag, "_best_mv"}, CW'(best_mv), CW'(1'b0));
  endtask

  task automatic releaseResults(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput({tag, "_release_busy"}, CW'(busy), CW'(1'b0));
    checkOutput({tag, "_release_res_valid"}, CW'(res_valid), CW'(1'b0));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    sad_valid = 1'b0;
    res_ready = 1'b0;
    sad_in    = '0;
    for (int l = 0; l < LANES; l++)
      all_first_mv[l*2*MV_W +: 2*MV_W] = {MV_W'(-SR), MV_W'(-SR)};

    $display("[TB] reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkReset("reset");

    $display("[TB] V-shaped lane 40");
    fillRandom(0, 65535);
    for (int k = 0; k < N_BEATS; k++)
      tbl[k][40] = (k < 4) ? 9 - k : k + 1;
    buildModel();
    applyStimulus(N_BEATS, 1'b0, 1'b0);
    checkResults("vshape");
    checkOutput("vshape_lane40_sad", CW'(best_sad[40*SAD_W +: SAD_W]), CW'(16'd5));
    checkOutput("vshape_lane40_mv", CW'(best_mv[40*2*MV_W +: 2*MV_W]), CW'(4'b0000));
    releaseResults("vshape");
    checkOutput("idle_hold_sad", best_sad, exp_sad);
    for (int i = 0; i < 3; i++) begin
      sad_valid = 1'b1;
      driveJunk();
      @(negedge clk);
    end
    sad_valid = 1'b0;
    checkOutput("idle_ignore_valid_busy", CW'(busy), CW'(1'b0));
    checkOutput("idle_ignore_valid_sad", best_sad, exp_sad);
    checkOutput("idle_ignore_valid_mv", CW'(best_mv), CW'(exp_mv));

    $display("[TB] ties");
    for (int k = 0; k < N_BEATS; k++)
      for (int l = 0; l < LANES; l++)
        tbl[k][l] = 3;
    buildModel();
    applyStimulus(N_BEATS, 1'b0, 1'b0);
    checkResults("ties");
    checkOutput("ties_first_mv", CW'(best_mv), CW'(all_first_mv));
    releaseResults("ties");

    $display("[TB] back-pressure");
    fillRandom(0, 15);
    buildModel();
    applyStimulus(N_BEATS, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      sad_valid = 1'b1;
      start     = 1'b1;
      driveJunk();
      @(negedge clk);
      checkOutput("bp_busy", CW'(busy), CW'(1'b1));
      checkResults("bp");
    end
    sad_valid = 1'b0;
    start     = 1'b0;
    releaseResults("bp");

    $display("[TB] start together with res_ready");
    fillRandom(0, 255);
    buildModel();
    applyStimulus(N_BEATS, 1'b0, 1'b0);
    checkResults("collide");
    start     = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    res_ready = 1'b0;
    checkOutput("collide_busy_0", CW'(busy), CW'(1'b0));
    @(negedge clk);
    checkOutput("collide_busy_1", CW'(busy), CW'(1'b0));
    checkOutput("collide_res_valid", CW'(res_valid), CW'(1'b0));

    $display("[TB] gaps");
    fillRandom(0, 31);
    buildModel();
    applyStimulus(N_BEATS, 1'b1, 1'b0);
    checkResults("gaps");
    releaseResults("gaps");

    $display("[TB] reset mid-search");
    fillRandom(0, 65535);
    applyStimulus(4, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkReset("abort");
    fillRandom(0, 65535);
    buildModel();
    applyStimulus(N_BEATS, 1'b0, 1'b0);
    checkResults("after_abort");
    releaseResults("after_abort");

    $display("[TB] independent lanes");
    fillRandom(10, 1000);
    tbl[0][0]           = 0;
    tbl[N_BEATS-1][39]  = 0;
    buildModel();
    applyStimulus(N_BEATS, 1'b0, 1'b0);
    checkResults("indep");
    checkOutput("indep_lane0_mv", CW'(best_mv[0 +: 2*MV_W]), CW'(4'b1111));
    checkOutput("indep_lane39_mv", CW'(best_mv[39*2*MV_W +: 2*MV_W]), CW'(4'b0101));
    releaseResults("indep");

    $display("[TB] random searches");
    for (int r = 0; r < 4; r++) begin
      fillRandom(0, (r % 2 == 0) ? 65535 : 7);
      if (r == 3)
        tbl[$urandom_range(N_BEATS-1, 0)][$urandom_range(LANES-1, 0)] = 65535;
      buildModel();
      applyStimulus(N_BEATS, r[0], 1'b1);
      checkResults("random");
      releaseResults("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
